// File: rtl/mod_counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and helpers for the programmable counter bank.
//   cnt_dir_e   : count direction (DIR_DOWN / DIR_UP)
//   cnt_mode_e  : boundary behaviour (MODE_WRAP / MODE_SAT)
//   is_boundary : true when the next step in the given direction crosses the
//                 count range 0..limit. Operands are zero-extended to
//                 CNT_MAX_W bits, so counters up to CNT_MAX_W bits wide can use it.
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  localparam int unsigned CNT_MAX_W = 32;

  // An up step is a boundary step at or above the limit. Testing with >= rather
  // than == also covers a count stranded above a limit that was just lowered.
  function automatic logic is_boundary(
    input cnt_dir_e             dir,
    input logic [CNT_MAX_W-1:0] cnt,
    input logic [CNT_MAX_W-1:0] limit
  );
    logic res;
    if (dir == DIR_UP) res = (cnt >= limit);
    else               res = (cnt == '0);
    return res;
  endfunction

endpackage

// File: rtl/mod_counter_bank_if.sv
// -----------------------------------------------------------------------------
// mod_counter_bank_if
// Control/status bus of the counter bank. Signal suffixes are written from the
// counter bank's point of view (_i = into the bank, _o = out of the bank).
//   presc_i    : shared prescaler divide value (tick every presc_i+1 cycles)
//   en_i       : per-channel count enable
//   clr_i      : per-channel synchronous clear of count, tc and ovf
//   load_i     : per-channel synchronous load strobe
//   load_val_i : per-channel load value
//   limit_i    : per-channel maximum count (range 0..limit)
//   dir_i      : per-channel direction, 1 = up, 0 = down
//   mode_i     : per-channel mode, 0 = wrap, 1 = saturate
//   ovf_clr_i  : per-channel clear of the sticky overflow flag
//   cnt_o      : per-channel count
//   tc_o       : per-channel terminal-count pulse
//   ovf_o      : per-channel sticky overflow flag
//   tick_o     : registered prescaler tick
// Modports: master drives the controls (user logic), slave is the bank.
// -----------------------------------------------------------------------------
interface mod_counter_bank_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 4
);

  logic [PRESC_W-1:0]           presc_i;
  logic [NUM_CH-1:0]            en_i;
  logic [NUM_CH-1:0]            clr_i;
  logic [NUM_CH-1:0]            load_i;
  logic [NUM_CH-1:0][WIDTH-1:0] load_val_i;
  logic [NUM_CH-1:0][WIDTH-1:0] limit_i;
  logic [NUM_CH-1:0]            dir_i;
  logic [NUM_CH-1:0]            mode_i;
  logic [NUM_CH-1:0]            ovf_clr_i;
  logic [NUM_CH-1:0][WIDTH-1:0] cnt_o;
  logic [NUM_CH-1:0]            tc_o;
  logic [NUM_CH-1:0]            ovf_o;
  logic                         tick_o;

  modport master (
    output presc_i, en_i, clr_i, load_i, load_val_i, limit_i,
           dir_i, mode_i, ovf_clr_i,
    input  cnt_o, tc_o, ovf_o, tick_o
  );

  modport slave (
    input  presc_i, en_i, clr_i, load_i, load_val_i, limit_i,
           dir_i, mode_i, ovf_clr_i,
    output cnt_o, tc_o, ovf_o, tick_o
  );

endinterface

// File: rtl/mod_counter_bank_ch.sv
// -----------------------------------------------------------------------------
// mod_counter_ch
// One programmable modulo counter channel: count, terminal-count pulse and
// sticky overflow registers plus the clear > load > step priority logic.
// All outputs are registered; the step decision uses the bank's combinational
// tick so the count update lines up with the registered tick_o of the bank.
// Ports:
//   clk_i, arst_ni : clock (rising edge), asynchronous active-low reset
//   tick_i         : prescaler tick (combinational, from the bank)
//   en_i           : count enable, a step happens on en_i & tick_i
//   clr_i          : clear count, tc and ovf
//   load_i         : load min(load_val_i, limit_i)
//   load_val_i     : load value
//   limit_i        : maximum count
//   dir_i, mode_i  : direction and boundary mode
//   ovf_clr_i      : clear sticky overflow (a same-cycle boundary step wins)
//   cnt_o, tc_o, ovf_o : registered count, tc pulse, sticky overflow
// WIDTH must not exceed counter_pkg::CNT_MAX_W.
// -----------------------------------------------------------------------------
module mod_counter_ch
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] limit_i,
  input  cnt_dir_e         dir_i,
  input  cnt_mode_e        mode_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q,  tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_bound;

  // Clamp into the count range. Used for loads and for the saturate hold,
  // which must pull a count stranded above a lowered limit back to the limit.
  function automatic logic [WIDTH-1:0] clamp_to_limit(
    input logic [WIDTH-1:0] val,
    input logic [WIDTH-1:0] lim
  );
    return (val > lim) ? lim : val;
  endfunction

  // Wrap target: an up step re-enters at 0, a down step re-enters at the limit.
  function automatic logic [WIDTH-1:0] wrap_target(
    input cnt_dir_e         dir,
    input logic [WIDTH-1:0] lim
  );
    return (dir == DIR_UP) ? '0 : lim;
  endfunction

  always_comb begin
    step     = en_i & tick_i;
    at_bound = is_boundary(dir_i, CNT_MAX_W'(cnt_q), CNT_MAX_W'(limit_i));

    cnt_d = cnt_q;
    tc_d  = 1'b0;
    // A boundary step below overrides this, so set beats ovf_clr_i.
    ovf_d = ovf_q & ~ovf_clr_i;

    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      cnt_d = clamp_to_limit(load_val_i, limit_i);
    end else if (step) begin
      if (at_bound) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        cnt_d = (mode_i == MODE_SAT) ? clamp_to_limit(cnt_q, limit_i)
                                     : wrap_target(dir_i, limit_i);
      end else if (dir_i == DIR_UP) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else begin
        // Also walks a count above a lowered limit back down one per step.
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mod_counter_bank.sv
// -----------------------------------------------------------------------------
// mod_counter_bank
// Bank of NUM_CH independent programmable modulo counters sharing one
// free-running clock prescaler. Each channel has a runtime limit, up/down
// direction, wrap/saturate mode, synchronous clear and load, a registered
// terminal-count pulse and a sticky overflow flag.
// Ports:
//   clk_i   : clock, rising edge
//   arst_ni : asynchronous active-low reset of all state
//   bus     : mod_counter_bank_if.slave, carries every control and status
//             signal (see the interface header for the list)
// Latency is one cycle from any control input to cnt_o/tc_o/ovf_o; tick_o is
// the registered prescaler tick and is aligned with the count it caused.
// -----------------------------------------------------------------------------
module mod_counter_bank
  import counter_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  mod_counter_bank_if.slave bus
);

  logic [PRESC_W-1:0]           presc_q, presc_d;
  logic                         tick_q,  tick_d;
  logic [NUM_CH-1:0][WIDTH-1:0] cnt_w;
  logic [NUM_CH-1:0]            tc_w;
  logic [NUM_CH-1:0]            ovf_w;

  // Prescaler. The >= compare means a divide value lowered below the current
  // prescaler count fires on the next cycle instead of running round 2^PRESC_W.
  always_comb begin
    tick_d  = (presc_q >= bus.presc_i);
    presc_d = tick_d ? '0 : presc_q + PRESC_W'(1);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.tick_o = tick_q;

  // Channels step on the combinational tick so the count update and tick_o
  // appear in the same cycle.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mod_counter_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk_i      (clk_i),
      .arst_ni    (arst_ni),
      .tick_i     (tick_d),
      .en_i       (bus.en_i[g]),
      .clr_i      (bus.clr_i[g]),
      .load_i     (bus.load_i[g]),
      .load_val_i (bus.load_val_i[g]),
      .limit_i    (bus.limit_i[g]),
      .dir_i      (cnt_dir_e'(bus.dir_i[g])),
      .mode_i     (cnt_mode_e'(bus.mode_i[g])),
      .ovf_clr_i  (bus.ovf_clr_i[g]),
      .cnt_o      (cnt_w[g]),
      .tc_o       (tc_w[g]),
      .ovf_o      (ovf_w[g])
    );
  end

  assign bus.cnt_o = cnt_w;
  assign bus.tc_o  = tc_w;
  assign bus.ovf_o = ovf_w;

endmodule
